// File: rtl/ahb_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_mem_arbiter_if
// Groups the signals between the two AHB-lite masters (IF = instruction
// fetch, LS = load/store) and the shared single-port RAM around the
// arbiter.
//   if_* / ls_*  : per-master address/data phase inputs, hrdata/hready back
//   mem_*        : RAM port (mem_rdata_i is valid the cycle after a read)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (masters + RAM)
// ---------------------------------------------------------------------------
interface ahb_mem_arbiter_if #(
  parameter int MEM_AW = 12
);
  logic              if_hsel_i,   ls_hsel_i;
  logic [1:0]        if_htrans_i, ls_htrans_i;
  logic [31:0]       if_haddr_i,  ls_haddr_i;
  logic              if_hwrite_i, ls_hwrite_i;
  logic [2:0]        if_hsize_i,  ls_hsize_i;
  logic [31:0]       if_hwdata_i, ls_hwdata_i;
  logic [31:0]       if_hrdata_o, ls_hrdata_o;
  logic              if_hready_o, ls_hready_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  if_hsel_i, if_htrans_i, if_haddr_i, if_hwrite_i, if_hsize_i, if_hwdata_i,
    input  ls_hsel_i, ls_htrans_i, ls_haddr_i, ls_hwrite_i, ls_hsize_i, ls_hwdata_i,
    output if_hrdata_o, if_hready_o, ls_hrdata_o, ls_hready_o,
    output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_hsel_i, if_htrans_i, if_haddr_i, if_hwrite_i, if_hsize_i, if_hwdata_i,
    output ls_hsel_i, ls_htrans_i, ls_haddr_i, ls_hwrite_i, ls_hsize_i, ls_hwdata_i,
    input  if_hrdata_o, if_hready_o, ls_hrdata_o, ls_hready_o,
    input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/ahb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_mem_arbiter
// Shares one zero-wait-state single-port RAM between two AHB-lite masters.
// One address phase is granted per cycle. Reads hit the RAM in the grant
// cycle; writes are latched and hit the RAM in the following cycle, when
// the write data phase is on the bus. While a latched write owns the RAM
// port, reads are held off but a new write may still be granted.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - ahb_mem_arbiter_if.slave (both masters + RAM port)
// Configuration:
//   ARB_RR_EN - when defined, ties are resolved round-robin (the master
//               granted last loses the next tie); otherwise LS always wins.
// ---------------------------------------------------------------------------
module ahb_mem_arbiter #(
  parameter int MEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  ahb_mem_arbiter_if.slave   bus
);

  typedef enum logic { M_IF = 1'b0, M_LS = 1'b1 } master_e;

  // Index 0 = IF, index 1 = LS.
  logic [1:0]        req, elig, gnt, hwrite;
  logic [1:0][31:0]  haddr;
  logic [1:0][2:0]   hsize;
  logic [31:0]       sel_addr;
  logic [2:0]        sel_size;
  logic              sel_write, any_gnt, ls_wins;
  logic              addr_unused;

  logic              wr_pend_q, wr_pend_d;
  master_e           wr_id_q,   wr_id_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_be_q,   wr_be_d;
  logic [1:0]        rd_vld_q,  rd_vld_d;
  logic [1:0][31:0]  hold_q,    hold_d;
`ifdef ARB_RR_EN
  logic              last_ls_q, last_ls_d;
`endif

  function automatic logic [3:0] size_be(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  size_be = 4'b0001 << a;
      3'b001:  size_be = 4'b0011 << {a[1], 1'b0};
      default: size_be = 4'b1111;
    endcase
  endfunction

  // Request decode and arbitration.
  // NOTE: combinational blocks use blocking '=' and give every output a
  // value up front, so no path can leave a signal unassigned (no latch).
  always_comb begin
    hwrite   = {bus.ls_hwrite_i, bus.if_hwrite_i};
    haddr[0] = bus.if_haddr_i;
    haddr[1] = bus.ls_haddr_i;
    hsize[0] = bus.if_hsize_i;
    hsize[1] = bus.ls_hsize_i;
    req[0]   = bus.if_hsel_i & bus.if_htrans_i[1];
    req[1]   = bus.ls_hsel_i & bus.ls_htrans_i[1];
    // A latched write owns the RAM port this cycle: only writes may proceed.
    for (int m = 0; m < 2; m++) elig[m] = req[m] & ~(wr_pend_q & ~hwrite[m]);
    ls_wins = 1'b1;
`ifdef ARB_RR_EN
    ls_wins = ~last_ls_q;
`endif
    gnt[1]    = elig[1] & (~elig[0] | ls_wins);
    gnt[0]    = elig[0] & ~gnt[1];
    any_gnt   = |gnt;
    sel_addr  = gnt[1] ? haddr[1]  : haddr[0];
    sel_size  = gnt[1] ? hsize[1]  : hsize[0];
    sel_write = gnt[1] ? hwrite[1] : hwrite[0];
  end

  assign addr_unused = ^sel_addr[31:MEM_AW+2];

  // Next-state logic.
  always_comb begin
    wr_pend_d = any_gnt & sel_write;
    wr_id_d   = wr_id_q;
    wr_addr_d = wr_addr_q;
    wr_be_d   = wr_be_q;
    if (any_gnt & sel_write) begin
      wr_id_d   = gnt[1] ? M_LS : M_IF;
      wr_addr_d = sel_addr[MEM_AW+1:2];
      wr_be_d   = size_be(sel_size, sel_addr[1:0]);
    end
    for (int m = 0; m < 2; m++) begin
      rd_vld_d[m] = gnt[m] & ~hwrite[m];
      // Capture the RAM word in its return cycle so it survives a stall.
      hold_d[m]   = rd_vld_q[m] ? bus.mem_rdata_i : hold_q[m];
    end
`ifdef ARB_RR_EN
    last_ls_d = any_gnt ? gnt[1] : last_ls_q;
`endif
  end

  // Outputs. Gated by rst so a request held during reset cannot reach the RAM.
  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0000;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (!rst) begin
      if (wr_pend_q) begin
        bus.mem_en_o    = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = wr_addr_q;
        bus.mem_be_o    = wr_be_q;
        bus.mem_wdata_o = (wr_id_q == M_LS) ? bus.ls_hwdata_i : bus.if_hwdata_i;
      end else if (any_gnt && !sel_write) begin
        bus.mem_en_o   = 1'b1;
        bus.mem_addr_o = sel_addr[MEM_AW+1:2];
        bus.mem_be_o   = 4'b1111;
      end
    end
    bus.if_hready_o = rst | ~req[0] | gnt[0];
    bus.ls_hready_o = rst | ~req[1] | gnt[1];
    bus.if_hrdata_o = rd_vld_q[0] ? bus.mem_rdata_i : hold_q[0];
    bus.ls_hrdata_o = rd_vld_q[1] ? bus.mem_rdata_i : hold_q[1];
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values; the hold registers are reset because they drive hrdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      wr_id_q   <= M_IF;
      wr_addr_q <= '0;
      wr_be_q   <= 4'b0000;
      rd_vld_q  <= 2'b00;
      hold_q    <= '0;
`ifdef ARB_RR_EN
      last_ls_q <= 1'b0;
`endif
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_id_q   <= wr_id_d;
      wr_addr_q <= wr_addr_d;
      wr_be_q   <= wr_be_d;
      rd_vld_q  <= rd_vld_d;
      hold_q    <= hold_d;
`ifdef ARB_RR_EN
      last_ls_q <= last_ls_d;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_mem_arbiter
// Directed checks of reset, read/write timing, arbitration and stalls,
// followed by two independent random AHB masters. Read results are
// predicted from a byte-level shadow of memory updated in bus acceptance
// order and checked by a monitor when each read data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_mem_arbiter;

  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  localparam logic [2:0] SZ_W    = 3'b010;
  localparam logic [2:0] SZ_B    = 3'b000;

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  logic mon_en = 1'b0;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;

  logic [31:0] ram [0:4095];
  logic [7:0]  shadow [0:255];
  logic [31:0] exp_if_q [$];
  logic [31:0] exp_ls_q [$];
  logic [1:0]  dph_rd = 2'b00;

  ahb_mem_arbiter_if #(.MEM_AW(12)) bus ();

  ahb_mem_arbiter #(.MEM_AW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Synchronous RAM model: write with byte enables, read data next cycle.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      bus.mem_rdata_i <= '0;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be_o[b]) ram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end else begin
        bus.mem_rdata_i <= ram[bus.mem_addr_o];
      end
    end
  end

  always @(posedge clk) if (bus.mem_we_o) we_count <= we_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a read data phase completes when its master sees hready=1.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.if_hsel_i && bus.if_htrans_i[1] && bus.ls_hsel_i && bus.ls_htrans_i[1])
        check("one_grant_per_cycle", {31'd0, bus.if_hready_o & bus.ls_hready_o}, 32'd0);
      if (bus.if_hready_o) begin
        if (dph_rd[0]) begin
          if (exp_if_q.size() == 0) check("if_scoreboard_underflow", 32'd1, 32'd0);
          else check("if_rand_rdata", bus.if_hrdata_o, exp_if_q.pop_front());
        end
        dph_rd[0] <= bus.if_hsel_i & bus.if_htrans_i[1] & ~bus.if_hwrite_i;
      end
      if (bus.ls_hready_o) begin
        if (dph_rd[1]) begin
          if (exp_ls_q.size() == 0) check("ls_scoreboard_underflow", 32'd1, 32'd0);
          else check("ls_rand_rdata", bus.ls_hrdata_o, exp_ls_q.pop_front());
        end
        dph_rd[1] <= bus.ls_hsel_i & bus.ls_htrans_i[1] & ~bus.ls_hwrite_i;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit ls, input bit sel, input logic [1:0] tr,
                     input logic [31:0] a, input bit w, input logic [2:0] sz);
    if (ls) begin
      bus.ls_hsel_i = sel; bus.ls_htrans_i = tr; bus.ls_haddr_i = a;
      bus.ls_hwrite_i = w; bus.ls_hsize_i = sz;
    end else begin
      bus.if_hsel_i = sel; bus.if_htrans_i = tr; bus.if_haddr_i = a;
      bus.if_hwrite_i = w; bus.if_hsize_i = sz;
    end
  endtask

  task automatic wdat(input bit ls, input logic [31:0] d);
    if (ls) bus.ls_hwdata_i = d;
    else    bus.if_hwdata_i = d;
  endtask

  task automatic idle(input bit ls);
    drv(ls, 1'b0, HT_IDLE, 32'd0, 1'b0, SZ_W);
  endtask

  task automatic write_word(input bit ls, input logic [31:0] a, input logic [31:0] d);
    cyc(); drv(ls, 1'b1, HT_NSEQ, a, 1'b1, SZ_W);
    cyc(); idle(ls); wdat(ls, d);
    cyc();
  endtask

  task automatic pulse_rst();
    cyc(); rst = 1'b1; idle(0); idle(1);
    cyc(); rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_hready"}, {31'd0, bus.if_hready_o}, 32'd1);
    check({tag, "_ls_hready"}, {31'd0, bus.ls_hready_o}, 32'd1);
    check({tag, "_if_hrdata"}, bus.if_hrdata_o, 32'd0);
    check({tag, "_ls_hrdata"}, bus.ls_hrdata_o, 32'd0);
    check({tag, "_mem_en"},    {31'd0, bus.mem_en_o}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, bus.mem_we_o}, 32'd0);
    check({tag, "_mem_be"},    {28'd0, bus.mem_be_o}, 32'd0);
    check({tag, "_mem_addr"},  {20'd0, bus.mem_addr_o}, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
  endtask

  function automatic logic hr(input bit ls);
    return ls ? bus.ls_hready_o : bus.if_hready_o;
  endfunction

  // Random AHB master: pipelined address/data phases, shadow updated at
  // acceptance, expected read data queued for the monitor.
  task automatic run_master(input bit ls, input int n);
    logic [31:0] a, d, pend_wd, wa;
    logic [2:0]  sz;
    bit          w, acc;
    int          kind;
    pend_wd = '0;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        drv(ls, kind != 0, (kind == 2) ? HT_BUSY : HT_IDLE, 32'($urandom_range(0, 63)), 1'b0, SZ_W);
        wdat(ls, pend_wd);
        #3;
        check(ls ? "ls_idle_hready" : "if_idle_hready", {31'd0, hr(ls)}, 32'd1);
        cyc();
      end
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 15) * 4);
      if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      drv(ls, 1'b1, HT_NSEQ, a, w, sz);
      wdat(ls, pend_wd);
      #3;
      acc = hr(ls);
      for (int s = 0; s < 500 && !acc; s++) begin
        @(posedge clk); #4;
        acc = hr(ls);
      end
      if (!acc) begin
        check(ls ? "ls_accept_timeout" : "if_accept_timeout", 32'd1, 32'd0);
      end else if (w) begin
        for (int k = 0; k < (1 << sz); k++) shadow[a + 32'(k)] = d[8*((a + 32'(k)) % 4) +: 8];
        pend_wd = d;
      end else begin
        wa = {a[31:2], 2'b00};
        if (ls) exp_ls_q.push_back({shadow[wa+3], shadow[wa+2], shadow[wa+1], shadow[wa]});
        else    exp_if_q.push_back({shadow[wa+3], shadow[wa+2], shadow[wa+1], shadow[wa]});
      end
      cyc();
    end
    idle(ls);
    wdat(ls, pend_wd);
  endtask

  initial begin
    int wc;
    bit exp_ls;
    rst = 1'b1; ram_clr = 1'b1;
    idle(0); idle(1); wdat(0, 32'd0); wdat(1, 32'd0);
    repeat (2) cyc();
    ram_clr = 1'b0;
    // Requests held during reset must not leak to the outputs.
    drv(0, 1'b1, HT_NSEQ, 32'h10, 1'b0, SZ_W);
    drv(1, 1'b1, HT_NSEQ, 32'h20, 1'b1, SZ_W);
    #1 check_reset_outputs("rst");
    cyc(); rst = 1'b0; idle(0); idle(1);
    #1 check("idle_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    check("idle_mem_be", {28'd0, bus.mem_be_o}, 32'd0);

    // IF word write 0xDEADBEEF to 0x10: latched, RAM written next cycle.
    cyc(); drv(0, 1'b1, HT_NSEQ, 32'h10, 1'b1, SZ_W);
    #1 check("wr_grant_if_hready", {31'd0, bus.if_hready_o}, 32'd1);
    check("wr_grant_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    cyc(); idle(0); wdat(0, 32'hDEADBEEF);
    #1 check("wr_dphase_we", {31'd0, bus.mem_we_o}, 32'd1);
    check("wr_dphase_addr", {20'd0, bus.mem_addr_o}, 32'd4);
    check("wr_dphase_be", {28'd0, bus.mem_be_o}, 32'hF);
    check("wr_dphase_wdata", bus.mem_wdata_o, 32'hDEADBEEF);

    // IF read of 0x10.
    cyc(); drv(0, 1'b1, HT_NSEQ, 32'h10, 1'b0, SZ_W);
    #1 check("rd_grant_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    check("rd_grant_mem_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("rd_grant_addr", {20'd0, bus.mem_addr_o}, 32'd4);
    check("rd_grant_be", {28'd0, bus.mem_be_o}, 32'hF);
    cyc(); idle(0);
    #1 check("rd_data_if", bus.if_hrdata_o, 32'hDEADBEEF);
    check("rd_data_if_hready", {31'd0, bus.if_hready_o}, 32'd1);

    // LS byte write 0xAB to 0x23.
    cyc(); drv(1, 1'b1, HT_NSEQ, 32'h23, 1'b1, SZ_B);
    cyc(); idle(1); wdat(1, 32'hAB000000);
    #1 check("bytewr_we", {31'd0, bus.mem_we_o}, 32'd1);
    check("bytewr_addr", {20'd0, bus.mem_addr_o}, 32'd8);
    check("bytewr_be", {28'd0, bus.mem_be_o}, 32'h8);
    check("bytewr_wdata", bus.mem_wdata_o, 32'hAB000000);

    write_word(1'b1, 32'h40, 32'h11111111);
    write_word(1'b0, 32'h44, 32'h22222222);
    write_word(1'b0, 32'h48, 32'h33333333);

    // Tie after reset: LS wins, IF follows with back-to-back reads.
    pulse_rst();
    drv(0, 1'b1, HT_NSEQ, 32'h44, 1'b0, SZ_W);
    drv(1, 1'b1, HT_NSEQ, 32'h40, 1'b0, SZ_W);
    #1 check("tie_ls_hready", {31'd0, bus.ls_hready_o}, 32'd1);
    check("tie_if_hready", {31'd0, bus.if_hready_o}, 32'd0);
    check("tie_addr", {20'd0, bus.mem_addr_o}, 32'h10);
    cyc(); idle(1);
    #1 check("tie_if_next_hready", {31'd0, bus.if_hready_o}, 32'd1);
    check("tie_if_next_addr", {20'd0, bus.mem_addr_o}, 32'h11);
    check("tie_ls_rdata", bus.ls_hrdata_o, 32'h11111111);
    cyc(); drv(0, 1'b1, HT_NSEQ, 32'h48, 1'b0, SZ_W);
    #1 check("b2b_if_rdata0", bus.if_hrdata_o, 32'h22222222);
    check("b2b_if_addr", {20'd0, bus.mem_addr_o}, 32'h12);
    cyc(); idle(0);
    #1 check("b2b_if_rdata1", bus.if_hrdata_o, 32'h33333333);

    // Read data returned while the master's next address phase is stalled.
    cyc(); drv(0, 1'b1, HT_NSEQ, 32'h40, 1'b0, SZ_W);
    #1 check("hold_grant", {31'd0, bus.if_hready_o}, 32'd1);
    cyc(); drv(0, 1'b1, HT_NSEQ, 32'h44, 1'b0, SZ_W); drv(1, 1'b1, HT_NSEQ, 32'h48, 1'b0, SZ_W);
    #1 check("hold_stall_hready", {31'd0, bus.if_hready_o}, 32'd0);
    check("hold_stall_rdata", bus.if_hrdata_o, 32'h11111111);
    cyc(); idle(1);
    #1 check("hold_release_hready", {31'd0, bus.if_hready_o}, 32'd1);
    check("hold_release_rdata", bus.if_hrdata_o, 32'h11111111);
    check("hold_ls_rdata", bus.ls_hrdata_o, 32'h33333333);
    cyc(); idle(0);
    #1 check("hold_next_rdata", bus.if_hrdata_o, 32'h22222222);

    // LS write then IF read: read waits for the RAM write cycle.
    cyc(); drv(1, 1'b1, HT_NSEQ, 32'h4C, 1'b1, SZ_W);
    #1 check("wrrd_ls_hready", {31'd0, bus.ls_hready_o}, 32'd1);
    cyc(); idle(1); wdat(1, 32'h44444444); drv(0, 1'b1, HT_NSEQ, 32'h4C, 1'b0, SZ_W);
    #1 check("wrrd_if_stall", {31'd0, bus.if_hready_o}, 32'd0);
    check("wrrd_we", {31'd0, bus.mem_we_o}, 32'd1);
    check("wrrd_wdata", bus.mem_wdata_o, 32'h44444444);
    cyc();
    #1 check("wrrd_if_grant", {31'd0, bus.if_hready_o}, 32'd1);
    check("wrrd_rd_we", {31'd0, bus.mem_we_o}, 32'd0);
    check("wrrd_rd_addr", {20'd0, bus.mem_addr_o}, 32'h13);
    cyc(); idle(0);
    #1 check("wrrd_if_rdata", bus.if_hrdata_o, 32'h44444444);

    // BUSY and IDLE with hsel=1 are not requests.
    cyc(); drv(0, 1'b1, HT_BUSY, 32'h10, 1'b0, SZ_W); drv(1, 1'b1, HT_IDLE, 32'h20, 1'b1, SZ_W);
    #1 check("busy_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    check("busy_if_hready", {31'd0, bus.if_hready_o}, 32'd1);
    check("idle_ls_hready", {31'd0, bus.ls_hready_o}, 32'd1);
    cyc(); idle(0); idle(1);

    // Continuous reads from both masters.
    pulse_rst();
    drv(0, 1'b1, HT_NSEQ, 32'h40, 1'b0, SZ_W);
    drv(1, 1'b1, HT_NSEQ, 32'h44, 1'b0, SZ_W);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      exp_ls = (i % 2) == 0;
`else
      exp_ls = 1'b1;
`endif
      #1 check("cont_ls_hready", {31'd0, bus.ls_hready_o}, {31'd0, exp_ls});
      check("cont_if_hready", {31'd0, bus.if_hready_o}, {31'd0, ~exp_ls});
      cyc();
    end
    idle(0); idle(1);

    // Reset while a write is latched: the write is dropped.
    cyc(); wc = we_count;
    drv(1, 1'b1, HT_NSEQ, 32'h50, 1'b1, SZ_W);
    #1 check("rstwr_grant", {31'd0, bus.ls_hready_o}, 32'd1);
    cyc(); rst = 1'b1; idle(1); wdat(1, 32'h55555555);
    #1 check_reset_outputs("rstwr0");
    cyc();
    #1 check_reset_outputs("rstwr1");
    rst = 1'b0;
    cyc();
    check("rstwr_no_we", 32'(we_count), 32'(wc));
    drv(1, 1'b1, HT_NSEQ, 32'h50, 1'b0, SZ_W);
    cyc(); idle(1);
    #1 check("rstwr_word_unchanged", bus.ls_hrdata_o, 32'd0);

    // Random traffic from both masters.
    cyc(); rst = 1'b1; ram_clr = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    cyc(); rst = 1'b0; ram_clr = 1'b0;
    mon_en = 1'b1;
    fork
      run_master(1'b0, 150);
      run_master(1'b1, 150);
    join
    repeat (3) cyc();
    check("if_scoreboard_drained", 32'(exp_if_q.size()), 32'd0);
    check("ls_scoreboard_drained", 32'(exp_ls_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
AHB_MEM_ARBITER -- requirements
Module: ahb_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning word-address width of the shared RAM.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports if_hsel_i / ls_hsel_i  input  1  master selects the memory.
REQ-005 SHALL have ports if_htrans_i / ls_htrans_i  input  2  AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-006 SHALL have ports if_haddr_i / ls_haddr_i  input  32  byte address of the address phase.
REQ-007 SHALL have ports if_hwrite_i / ls_hwrite_i  input  1  1=write, 0=read.
REQ-008 SHALL have ports if_hsize_i / ls_hsize_i  input  3  000=byte, 001=half, 010=word.
REQ-009 SHALL have ports if_hwdata_i / ls_hwdata_i  input  32  write data of the data phase.
REQ-010 SHALL have ports if_hrdata_o / ls_hrdata_o  output  32  read data.
REQ-011 SHALL have ports if_hready_o / ls_hready_o  output  1  transfer-done/accept per master.
REQ-012 SHALL have ports mem_en_o  output  1  RAM access enable; mem_we_o  output  1  write strobe; mem_be_o  output  4  byte enables.
REQ-013 SHALL have ports mem_addr_o  output  MEM_AW  word address (haddr[MEM_AW+1:2]); mem_wdata_o  output  32; mem_rdata_i  input  32, valid the cycle after a read enable.

Function
REQ-014 A master SHALL request in a cycle when hsel_i=1 and htrans_i[1]=1; BUSY and IDLE SHALL be ignored.
REQ-015 At most one address phase SHALL be granted per cycle; the granted master's hready_o=1, a requesting non-granted master's hready_o=0, and a master that is not requesting SHALL get hready_o=1 unless REQ-019 applies.
REQ-016 Fixed priority SHALL be used: LS over IF (unless REQ-026 applies).
REQ-017 A granted read SHALL assert mem_en_o=1, mem_we_o=0 and the decoded address in the same cycle; the data SHALL be returned in the next cycle (zero wait states).
REQ-018 A granted write SHALL latch address, size and master id; in the next cycle mem_en_o=1, mem_we_o=1 and mem_wdata_o = that master's hwdata_i.
REQ-019 In a cycle where a latched write occupies the RAM port, read requests SHALL NOT be granted (hready_o=0 for that requester); write requests MAY be granted in that cycle.
REQ-020 Byte enables: byte -> 4'b0001<<haddr[1:0]; half -> 4'b0011<<{haddr[1],1'b0}; word -> 4'b1111; reads SHALL drive 4'b1111.
REQ-021 Each master SHALL have a 32-bit hold register: its hrdata_o = mem_rdata_i in the cycle after its read grant; that value SHALL be captured and re-presented unchanged while that master's hready_o stays 0.
REQ-022 Simultaneous requests SHALL be resolved in the same cycle with no bubble; the loser SHALL retain its address phase, which is re-arbitrated each cycle.
REQ-023 Memory outputs SHALL be 0 in cycles with no grant and no pending write.

Reset
REQ-024 While rst=1: hready_o=1 for both masters, hrdata_o=0, mem_en_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0; the pending write, the hold registers and the round-robin pointer SHALL be cleared.
REQ-025 Reset asserted mid-write SHALL drop the latched write with no RAM write issued; the first grant after deassertion SHALL follow the cleared priority state (LS wins ties).

Configuration
REQ-026 With macro ARB_RR_EN defined, ties SHALL use round-robin: the master granted most recently loses the next tie, and the pointer updates only on a grant. Without ARB_RR_EN, REQ-016 fixed priority SHALL apply and no pointer state SHALL exist.

Verification
REQ-027 IF read at 0x10 alone, RAM word 4 = 0xDEADBEEF -> mem_en_o=1, mem_addr_o=4 in the grant cycle; if_hrdata_o=0xDEADBEEF with if_hready_o=1 next cycle.
REQ-028 LS byte write 0xAB to 0x23 -> next cycle mem_we_o=1, mem_addr_o=8, mem_be_o=4'b1000.
REQ-029 IF read and LS read in the same cycle, fixed priority -> ls_hready_o=1, if_hready_o=0; IF granted the following cycle; back-to-back IF read data still delivered.
REQ-030 LS write followed immediately by an IF read -> IF read stalled one cycle (if_hready_o=0), granted in the cycle after the RAM write.
REQ-031 ARB_RR_EN, both masters issue continuous reads for 6 cycles -> grants alternate LS, IF, LS, IF, LS, IF.
REQ-032 rst pulsed during a latched write -> no mem_we_o pulse; all outputs at reset values while rst=1.
